// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-memory access, IDLE -> REQ -> DONE.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of truncating them.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        in_half, in_word;
    logic [31:0] addr_aligned;
    logic        st_byte, st_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign access  = start & (MemRead | MemWrite);
    assign in_half = (funct3[1:0] == 2'b01);
    assign in_word = funct3[1];
    assign addr_aligned = in_word ? {addr[31:2], 2'b00} :
                          in_half ? {addr[31:1], 1'b0}  : addr;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic in_mis;
    assign in_mis = (in_half & addr[0]) | (in_word & (addr[1:0] != 2'b00));
`endif

    // Load formatting works on the captured (already aligned) address
    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   ld_val = funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        mem_data_d = mem_data_q;
        bus_err_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    wdata_d  = wdata;
                    funct3_d = funct3;
                    we_d     = MemWrite & ~MemRead;
                    cnt_d    = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d   = addr;
                    if (in_mis) begin
                        state_d    = S_DONE;
                        mis_d      = 1'b1;
                        mem_data_d = '0;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    addr_d   = addr_aligned;
                    state_d  = S_REQ;
`endif
                end
            end
            S_REQ: begin
                cnt_d = (cnt_q < TO_CNT) ? cnt_q + 8'd1 : cnt_q;
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        mem_data_d = ld_val;
                    end
                end else if (cnt_d == TO_CNT) begin
                    state_d    = S_DONE;
                    bus_err_d  = 1'b1;
                    mem_data_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            mem_data_q <= '0;
            bus_err_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
            bus_err_q  <= bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign st_byte = (funct3_q[1:0] == 2'b00);
    assign st_half = (funct3_q[1:0] == 2'b01);

    always_comb begin
        if (st_byte) begin
            mem_wdata = {4{wdata_q[7:0]}};
            mem_wstrb = 4'b0001 << addr_q[1:0];
        end else if (st_half) begin
            mem_wdata = {2{wdata_q[15:0]}};
            mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        end else begin
            mem_wdata = wdata_q;
            mem_wstrb = 4'b1111;
        end
        if (!we_q) begin
            mem_wstrb = 4'b0000;
        end
    end

    assign mem_req  = (state_q == S_REQ);
    assign mem_we   = we_q;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_data = mem_data_q;
    assign stall    = ((state_q == S_IDLE) & access) | (state_q == S_REQ);
    assign done     = (state_q == S_DONE);
    assign bus_err  = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, corner sequences, random vs. reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, start, MemRead, MemWrite, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_req, mem_we, stall, done, misaligned, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic [3:0]  mem_wstrb;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_data(mem_data), .stall(stall), .done(done), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        int          dly;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes from the width code, lanes from byte offset.
    function automatic void model(input logic mr, input logic mw, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                  output logic e_we, output logic [31:0] e_addr, output logic [3:0] e_strb,
                                  output logic [31:0] e_wdata, output logic [31:0] e_data,
                                  output logic e_mis);
        int unsigned size, off;
        logic [63:0] mask, v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        off    = a % 4;
        e_mis  = 1'b0;
        e_we   = mw && !mr;
        e_addr = a - off;
        e_strb = '0;
        e_wdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % size != 0) begin
            e_mis = 1'b1;
            e_data = '0;
            last_data = '0;
            return;
        end
`endif
        off = off - (off % size);
        if (e_we) begin
            e_strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++)
                e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            e_data = last_data;
        end else begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v = ({32'b0, rd} >> (8 * off)) & mask;
            if ((f3 == 3'b000 || f3 == 3'b001) && v[8*size-1])
                v = v | ~mask;
            e_data = v[31:0];
            last_data = e_data;
        end
    endfunction

    task automatic do_access(input logic mr, input logic mw, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int dly, input logic e_we, input logic [31:0] e_addr,
                             input logic [3:0] e_strb, input logic [31:0] e_wdata,
                             input logic [31:0] e_data, input logic e_mis);
        start = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk("stall_at_start", {31'b0, stall}, 32'd1);
        tick();
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = $urandom; wdata = $urandom;
        #1;
        if (e_mis) begin
            chk("mis_no_req", {31'b0, mem_req}, 32'd0);
            chk("mis_done", {31'b0, done}, 32'd1);
            chk("mis_flag", {31'b0, misaligned}, 32'd1);
            chk("mis_data", mem_data, e_data);
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk("mem_req", {31'b0, mem_req}, 32'd1);
                chk("stall_req", {31'b0, stall}, 32'd1);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_strb});
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                if (i < dly) begin
                    mem_rdata = $urandom;
                    tick();
                end
            end
            mem_ack = 1'b1; mem_rdata = rd;
            tick();
            mem_ack = 1'b0; mem_rdata = $urandom;
            #1;
            chk("done", {31'b0, done}, 32'd1);
            chk("mem_data", mem_data, e_data);
            chk("bus_err_ok", {31'b0, bus_err}, 32'd0);
            chk("misaligned_ok", {31'b0, misaligned}, 32'd0);
            chk("stall_done", {31'b0, stall}, 32'd0);
            chk("req_done", {31'b0, mem_req}, 32'd0);
        end
        tick();
        chk("done_pulse", {31'b0, done}, 32'd0);
    endtask

    vec_t vt[10];

    initial begin
        logic        e_we, e_mis;
        logic [31:0] e_addr, e_wdata, e_data, a, wd, rd;
        logic [3:0]  e_strb;
        logic [2:0]  f3;
        logic        mr, mw;
        int          n;
        logic [2:0]  st_codes[6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        vt[0] = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80};
        vt[1] = '{0, 1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1, 32'h100, 4'hC, 32'hBEEF_BEEF, 32'hFFFF_FF80};
        vt[2] = '{1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1, 0, 32'h100, 4'h0, 32'h0, 32'h0000_8001};
        vt[3] = '{1, 0, 3'b001, 32'h100, 32'h0, 32'h0000_8765, 0, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_8765};
        vt[4] = '{1, 0, 3'b100, 32'h201, 32'h0, 32'h0000_AB00, 2, 0, 32'h200, 4'h0, 32'h0, 32'h0000_00AB};
        vt[5] = '{0, 1, 3'b000, 32'h203, 32'h1234_56C3, 32'h0, 0, 1, 32'h200, 4'h8, 32'hC3C3_C3C3, 32'h0000_00AB};
        vt[6] = '{0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h0, 3, 1, 32'h300, 4'hF, 32'hDEAD_BEEF, 32'h0000_00AB};
        vt[7] = '{1, 0, 3'b011, 32'h304, 32'h0, 32'hCAFE_F00D, 0, 0, 32'h304, 4'h0, 32'h0, 32'hCAFE_F00D};
        vt[8] = '{1, 1, 3'b010, 32'h400, 32'h5555_5555, 32'h1122_3344, 0, 0, 32'h400, 4'h0, 32'h0, 32'h1122_3344};
        vt[9] = '{1, 0, 3'b000, 32'h100, 32'h0, 32'h0000_007F, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0000_007F};

        rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        tick();

        for (int i = 0; i < 10; i++)
            do_access(vt[i].mr, vt[i].mw, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rd, vt[i].dly,
                      vt[i].e_we, vt[i].e_addr, vt[i].e_strb, vt[i].e_wdata, vt[i].e_data, 1'b0);
        last_data = 32'h0000_007F;

        // Misaligned word and half: trapped or truncated depending on the build.
`ifdef LSU_MISALIGN_TRAP_EN
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0, 1'b1);
        do_access(1, 0, 3'b001, 32'h103, 32'h0, 32'hF00D_1234, 0, 0, 32'h100, 4'h0, 32'h0, 32'h0, 1'b1);
        last_data = '0;
`else
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0, 32'h100, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        do_access(1, 0, 3'b001, 32'h103, 32'h0, 32'hF00D_1234, 0, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_F00D, 1'b0);
        last_data = 32'hFFFF_F00D;
`endif
        do_access(1, 0, 3'b010, 32'h700, 32'h0, 32'h0BAD_F00D, 0, 0, 32'h700, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Reset while a request is outstanding, then a stale ack.
        start = 1'b1; MemRead = 1'b1; funct3 = 3'b010; addr = 32'h600;
        tick();
        start = 1'b0; MemRead = 1'b0;
        #1;
        chk("abort_req_before", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_req_after", {31'b0, mem_req}, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_mem_data", mem_data, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_FFFF;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort_no_done", {31'b0, done}, 32'd0);
            chk("abort_no_req", {31'b0, mem_req}, 32'd0);
            chk("abort_data_kept0", mem_data, 32'd0);
            tick();
        end
        last_data = '0;
        do_access(1, 0, 3'b000, 32'h602, 32'h0, 32'h0042_0000, 0, 0, 32'h600, 4'h0, 32'h0, 32'h0000_0042, 1'b0);
        last_data = 32'h0000_0042;

        // Load with no acknowledge: bus error after TIMEOUT request cycles.
        start = 1'b1; MemRead = 1'b1; funct3 = 3'b010; addr = 32'h500;
        tick();
        start = 1'b0; MemRead = 1'b0;
        #1;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("timeout_req_cycles", n, 32'd16);
        chk("timeout_done", {31'b0, done}, 32'd1);
        chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
        chk("timeout_mem_data", mem_data, 32'd0);
        chk("timeout_stall", {31'b0, stall}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_no_done", {31'b0, done}, 32'd0);
        chk("late_ack_bus_err", {31'b0, bus_err}, 32'd0);
        chk("late_ack_data", mem_data, 32'd0);
        last_data = '0;

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 2))
                0: begin mr = 1; mw = 0; end
                1: begin mr = 0; mw = 1; end
                default: begin mr = 1; mw = 1; end
            endcase
            if (mw && !mr) f3 = st_codes[$urandom_range(0, 5)];
            else           f3 = 3'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; rd = $urandom;
            model(mr, mw, f3, a, wd, rd, e_we, e_addr, e_strb, e_wdata, e_data, e_mis);
            do_access(mr, mw, f3, a, wd, rd, $urandom_range(0, 5),
                      e_we, e_addr, e_strb, e_wdata, e_data, e_mis);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
